cuad_decimating_accumulator: RTL and testbench
==============================================

// Module: cuad_decimating_accumulator
// PURPOSE
//  Boxcar decimator for one lock-in quadrature channel, placed directly upstream of the quadrature
//  down-sampled capture FIFO (32-bit Avalon-ST sink, no ready).
//  Sums 2^k input samples, then emits one 32-bit sign-extended sum on out_data/out_valid.
//  Runs one armed capture of N output words, sized so the 8192-word FIFO cannot overflow.
//  Reports busy/done/overflow status to the CPU-side control registers.
// PARAMETERS
//  IN_WIDTH      16    signed input sample width
//  OUT_WIDTH     32    output word width; must be >= IN_WIDTH+MAX_LOG2
//  MAX_LOG2      10    largest decimation exponent k (factor 1024)
//  CNT_WIDTH     14    width of capture-length count (max 8192 words)
// PORTS
//  clock         in   1          single clock; all logic rising-edge
//  reset_n       in   1          asynchronous active-low reset
//  start         in   1          1-cycle pulse: arm a capture (honoured only in IDLE or DONE)
//  abort         in   1          1-cycle pulse: cancel capture, return to IDLE
//  decim_log2    in   4          k; decimation factor 2^k; sampled on start; values > MAX_LOG2 clamp to MAX_LOG2
//  n_capture     in   CNT_WIDTH  number of output words to emit; sampled on start
//  in_data       in   IN_WIDTH   signed input sample
//  in_valid      in   1          in_data qualifier; one sample per cycle max
//  fifo_full     in   1          full flag of the downstream FIFO
//  out_data      out  OUT_WIDTH  sign-extended sum of 2^k samples (Avalon-ST data)
//  out_valid     out  1          1-cycle strobe per output word (Avalon-ST valid)
//  busy          out  1          high in RUN
//  done          out  1          high in DONE until next start/abort
//  overflow      out  1          sticky: a word was emitted while fifo_full=1
// BEHAVIOUR
//  Reset:
//   - state=IDLE; out_data=0, out_valid=0, busy=0, done=0, overflow=0.
//   - Accumulator, sample counter and word counter are cleared.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE/DONE + start:
//     - latch k=min(decim_log2,MAX_LOG2) and N=n_capture.
//     - clear accumulator, both counters and overflow.
//     - go to RUN, or to DONE if N==0.
//   - RUN: each in_valid cycle adds sign-extended in_data to acc and increments sample count.
//     - The cycle accepting sample number 2^k: the register stage loads out_data=acc+in_data.
//     - On that same edge: out_valid=1 for exactly one cycle, acc and sample count restart at 0.
//     - No sample is lost or double-counted across a boundary; a sample on the next cycle starts the new sum.
//     - Latency: out_valid is high in the cycle after the edge that accepts the last sample.
//     - k=0: every valid sample is echoed one cycle later, sign-extended.
//   - When the word counter reaches N: go to DONE on the same edge as the final out_valid.
//     - in_valid is ignored from then on.
//   - DONE: done=1, busy=0; in_valid is ignored; start re-arms.
//   - abort (any state, priority over start and in_valid): next state IDLE.
//     - Partial sum discarded, no out_valid, done=0; overflow keeps its value.
//   - start while in RUN: ignored.
//  Arithmetic:
//   - Two's-complement, full precision (IN_WIDTH+MAX_LOG2 bits); no rounding, no saturation.
//   - out_data holds its last value between strobes.
//  Backpressure: none (sink has no ready).
//   - If out_valid is asserted while fifo_full=1, the word is still presented and overflow is set (sticky).
//  Reset asserted mid-capture: immediate return to the reset values above.
//  in_valid gaps of any length are allowed; the sum spans them.
// TESTING
//  1. k=2, N=3, in_data 1,2,3,...,12 back-to-back
//     -> out_data 10, 26, 42; out_valid one cycle after samples 4, 8, 12; then done=1.
//  2. k=3, N=1, eight samples of -32768
//     -> out_data 0xFFFC0000 (-262144); no wrap.
//  3. k=0, N=4, in_valid toggling 1,0,1,0..., data 5,-1,7,0
//     -> out_data 5, 0xFFFFFFFF, 7, 0, each one cycle after its sample; done after the 4th.
//  4. k=1, N=5, abort after 3 words plus 1 partial sample
//     -> no further out_valid; state IDLE, done=0.
//     -> then restart with N=1: first output is the sum of the next 2 samples only.
//  5. fifo_full=1 during the 2nd of 3 words -> word still strobed, overflow=1 stays set.
//     -> overflow cleared by the next start.
//  6. decim_log2=15 -> behaves as k=10 (1024 samples/word).
//     N=0 -> done next cycle, no out_valid.
//     reset_n low mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cuad_decimating_accumulator.sv
// Boxcar decimator for one lock-in quadrature channel: sums 2^k signed samples per output word
// and runs one armed capture of N words into a no-ready Avalon-ST FIFO sink.
module cuad_decimating_accumulator #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned MAX_LOG2  = 10,
  parameter int unsigned CNT_WIDTH = 14
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           decim_log2,
  input  logic [CNT_WIDTH-1:0] n_capture,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 fifo_full,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int unsigned SampW = MAX_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [3:0]           k_q, k_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [SampW-1:0]     samp_cnt_q, samp_cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overflow_q, overflow_d;

  logic [OUT_WIDTH-1:0] in_ext;
  logic [OUT_WIDTH-1:0] sum;
  logic                 last_samp;
  logic                 last_word;
  logic                 word_lost;

  assign in_ext    = {{(OUT_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign sum       = acc_q + in_ext;
  assign last_samp = (samp_cnt_q + SampW'(1)) == (SampW'(1) << k_q);
  assign last_word = (word_cnt_q + CNT_WIDTH'(1)) == n_q;
  // A word presented while the FIFO reports full is lost downstream.
  assign word_lost = out_valid_q & fifo_full;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      n_q         <= '0;
      word_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      word_cnt_q  <= word_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    word_cnt_d  = word_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q | word_lost;

    if (abort) begin
      state_d    = StIdle;
      acc_d      = '0;
      samp_cnt_d = '0;
      word_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            k_d        = (decim_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : decim_log2;
            n_d        = n_capture;
            acc_d      = '0;
            samp_cnt_d = '0;
            word_cnt_d = '0;
            overflow_d = word_lost;
            state_d    = (n_capture == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (in_valid) begin
            if (last_samp) begin
              out_data_d  = sum;
              out_valid_d = 1'b1;
              acc_d       = '0;
              samp_cnt_d  = '0;
              word_cnt_d  = word_cnt_q + CNT_WIDTH'(1);
              if (last_word) state_d = StDone;
            end else begin
              acc_d      = sum;
              samp_cnt_d = samp_cnt_q + SampW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    out_data  = out_data_q;
    out_valid = out_valid_q;
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_cuad_decimating_accumulator.sv
// Self-checking bench for cuad_decimating_accumulator: table vectors, directed corner sequences
// and random captures, each cycle compared against a queue-based reference model.
module tb_cuad_decimating_accumulator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, abort, in_valid, fifo_full;
  logic [3:0]  decim_log2;
  logic [13:0] n_capture;
  logic [15:0] in_data;
  logic [31:0] out_data;
  logic        out_valid, busy, done, overflow;

  cuad_decimating_accumulator dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .decim_log2 (decim_log2),
    .n_capture  (n_capture),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .fifo_full  (fifo_full),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 run, 2 done; samples of the current word kept in a queue.
  int          m_state, m_k, m_n, m_words;
  int          m_q[$];
  logic [31:0] m_data;
  bit          m_valid, m_ovf;
  logic [31:0] got_q[$];

  typedef struct {
    int               k;
    int               n;
    int               nsamp;
    bit               gaps;
    logic [11:0][15:0] d;
    logic [3:0][31:0]  exp;
    int               nexp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_k = 0; m_n = 0; m_words = 0;
    m_q.delete(); m_data = '0; m_valid = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit v, input logic [15:0] d,
                            input bit ff);
    bit set_ovf;
    int s;
    set_ovf = m_valid && ff;
    m_valid = 0;
    if (ab) begin
      m_state = 0;
      m_q.delete();
    end else if (st && m_state != 1) begin
      m_k     = (int'(decim_log2) > 10) ? 10 : int'(decim_log2);
      m_n     = int'(n_capture);
      m_words = 0;
      m_q.delete();
      m_ovf   = 0;
      m_state = (m_n == 0) ? 2 : 1;
    end else if (m_state == 1 && v) begin
      m_q.push_back(int'($signed(d)));
      if (m_q.size() == (1 << m_k)) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        m_data  = 32'(s);
        m_valid = 1;
        m_q.delete();
        m_words++;
        if (m_words == m_n) m_state = 2;
      end
    end
    if (set_ovf) m_ovf = 1;
  endtask

  // One clock: drive inputs, advance model, compare all outputs after the edge.
  task automatic cyc(input bit st, input bit ab, input bit v, input logic [15:0] d,
                     input bit ff);
    start = st; abort = ab; in_valid = v; in_data = d; fifo_full = ff;
    model_edge(st, ab, v, d, ff);
    @(posedge clock);
    #1;
    start = 0; abort = 0; in_valid = 0; fifo_full = 0;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_data", out_data, m_data);
    check("busy", {31'd0, busy}, {31'd0, m_state == 1});
    check("done", {31'd0, done}, {31'd0, m_state == 2});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (out_valid) got_q.push_back(out_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 16'($urandom), 0);
  endtask

  task automatic arm(input int k, input int n);
    decim_log2 = 4'(k);
    n_capture  = 14'(n);
    got_q.delete();
    cyc(1, 0, 0, 16'($urandom), 0);
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0].k = 2; vecs[0].n = 3; vecs[0].nsamp = 12; vecs[0].gaps = 0; vecs[0].nexp = 3;
    for (int i = 0; i < 12; i++) vecs[0].d[i] = 16'(i + 1);
    vecs[0].exp[0] = 32'd10; vecs[0].exp[1] = 32'd26; vecs[0].exp[2] = 32'd42;
    vecs[0].exp[3] = '0;
    vecs[1].k = 3; vecs[1].n = 1; vecs[1].nsamp = 8; vecs[1].gaps = 0; vecs[1].nexp = 1;
    for (int i = 0; i < 12; i++) vecs[1].d[i] = 16'h8000;
    vecs[1].exp = '0;
    vecs[1].exp[0] = 32'hFFFC0000;
    vecs[2].k = 0; vecs[2].n = 4; vecs[2].nsamp = 4; vecs[2].gaps = 1; vecs[2].nexp = 4;
    vecs[2].d = '0;
    vecs[2].d[0] = 16'd5; vecs[2].d[1] = 16'hFFFF; vecs[2].d[2] = 16'd7; vecs[2].d[3] = 16'd0;
    vecs[2].exp[0] = 32'd5; vecs[2].exp[1] = 32'hFFFFFFFF; vecs[2].exp[2] = 32'd7;
    vecs[2].exp[3] = 32'd0;

    reset_n = 0; start = 0; abort = 0; in_valid = 0; fifo_full = 0;
    in_data = '0; decim_log2 = '0; n_capture = '0;
    model_reset();
    #12;
    check("rst out_data", out_data, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst overflow", {31'd0, overflow}, 32'd0);
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;

    // Table-driven captures.
    foreach (vecs[t]) begin
      arm(vecs[t].k, vecs[t].n);
      for (int i = 0; i < vecs[t].nsamp; i++) begin
        cyc(0, 0, 1, vecs[t].d[i], 0);
        if (vecs[t].gaps) cyc(0, 0, 0, 16'($urandom), 0);
      end
      idle(3);
      check("vec word count", 32'(got_q.size()), 32'(vecs[t].nexp));
      for (int i = 0; i < vecs[t].nexp && i < got_q.size(); i++)
        check("vec word", got_q[i], vecs[t].exp[i]);
    end

    // Abort after 3 words plus one partial sample, then restart.
    arm(1, 5);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 16'(i + 1), 0);
    cyc(0, 1, 1, 16'd100, 0);
    idle(3);
    check("abort words", 32'(got_q.size()), 32'd3);
    check("abort done", {31'd0, done}, 32'd0);
    arm(1, 1);
    cyc(0, 0, 1, 16'd20, 0);
    cyc(0, 0, 1, 16'd22, 0);
    check("restart sum", out_data, 32'd42);
    idle(2);

    // fifo_full during the second of three words.
    arm(1, 3);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 16'(i * 3), (i == 4));
    idle(3);
    check("overflow sticky", {31'd0, overflow}, 32'd1);
    check("ovf word count", 32'(got_q.size()), 32'd3);
    arm(2, 0);
    check("overflow cleared", {31'd0, overflow}, 32'd0);
    check("n0 done", {31'd0, done}, 32'd1);
    idle(2);

    // decim_log2 beyond the maximum clamps to 1024 samples per word.
    arm(15, 1);
    for (int i = 0; i < 1024; i++) cyc(0, 0, 1, 16'($urandom), 0);
    idle(2);
    check("clamp words", 32'(got_q.size()), 32'd1);

    // Asynchronous reset in the middle of a capture.
    arm(2, 5);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 16'(i + 7), (i == 4));
    cyc(0, 0, 1, 16'd3, 0);
    #3 reset_n = 0;
    #1;
    check("arst out_data", out_data, 32'd0);
    check("arst out_valid", {31'd0, out_valid}, 32'd0);
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst done", {31'd0, done}, 32'd0);
    check("arst overflow", {31'd0, overflow}, 32'd0);
    model_reset();
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;
    idle(2);

    // Random captures with gaps, random fifo_full, stray starts and rare aborts.
    for (int c = 0; c < 25; c++) begin
      arm($urandom_range(0, 4), $urandom_range(0, 4));
      for (int i = 0; i < 600 && m_state == 1; i++)
        cyc(($urandom % 20) == 0, ($urandom % 150) == 0, ($urandom % 3) != 0,
            16'($urandom), ($urandom % 4) == 0);
      idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
